keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   4x4 matrix keypad scanner: input-side counterpart of the multiplexed 7-seg driver.
//   Drives one row low at a time, samples active-low columns and debounces them.
//   Emits a hex key code (0..F) with a single-cycle valid strobe for the counter/7-seg path.
//   Sits between board keypad pins and the display/control logic on the 50 MHz clock.
// PARAMETERS
//   SCAN_DIV        50_000  clk cycles per scan tick (1 kHz row rate at 50 MHz); >=2
//   DEBOUNCE_TICKS  20      consecutive stable ticks to accept press or release; >=1
//   REPEAT_DELAY    500     ticks held before first auto-repeat (KEYPAD_REPEAT_EN only)
//   REPEAT_RATE     100     ticks between later auto-repeats (KEYPAD_REPEAT_EN only)
// PORTS
//   clk        in   1  system clock, 50 MHz
//   reset      in   1  asynchronous, active-low
//   col_in     in   4  keypad columns, active-low, externally pulled up, asynchronous
//   row_out    out  4  keypad rows, active-low one-hot
//   key_code   out  4  last accepted key = row*4 + col
//   key_valid  out  1  one-clk pulse per accepted press (and per repeat)
//   key_held   out  1  high from accepted press until accepted release
// BEHAVIOUR
//   Reset values: row_out=4'b1110 (row 0), key_code=0, key_valid=0, key_held=0, FSM=SCAN,
//     prescaler=0, debounce cnt=0, synchronizer FFs=4'b1111.
//   col_in passes a 2-FF synchronizer; all decisions use the synchronized value.
//   Prescaler counts 0..SCAN_DIV-1; tick=1 for one clk when count==SCAN_DIV-1, then wraps to 0.
//   Everything below is evaluated on tick cycles only; row_out changes only on ticks.
//   Column pick: lowest-index low column wins when several are low.
//   FSM states:
//     SCAN: no column low -> advance row (3 wraps to 0). Column c low -> latch cand={row,c},
//       cnt=1, go DEBOUNCE, row frozen. If DEBOUNCE_TICKS==1, accept immediately.
//     DEBOUNCE: cand column still the picked column -> cnt++; when cnt==DEBOUNCE_TICKS:
//       key_code<=cand, key_valid pulse, key_held<=1, go PRESSED. Otherwise -> SCAN, advance row.
//     PRESSED: row frozen; cand column high -> rel_cnt++, low -> rel_cnt=0;
//       rel_cnt==DEBOUNCE_TICKS -> key_held<=0, go SCAN, advance row.
//   key_valid asserts in the clk after the accepting tick, lasts exactly 1 clk.
//   key_code holds its value until the next accepted press; never changes in SCAN/DEBOUNCE.
//   Other keys pressed while in PRESSED are ignored (no rollover).
//   Reset mid-operation: asynchronously forces all reset values; no strobe follows release.
// CONFIGURATION
//   KEYPAD_REPEAT_EN defined: in PRESSED, ticks with key still down count toward repeat;
//     first extra key_valid after REPEAT_DELAY ticks, then every REPEAT_RATE ticks,
//     same key_code; counter cleared on release or entry to PRESSED.
//   KEYPAD_REPEAT_EN undefined: exactly one key_valid per press; REPEAT_* are unused.
// STRUCTURE
//   keypad_pkg: FSM state encoding (SCAN/DEBOUNCE/PRESSED), ROW_IDLE=4'b1110, row/col widths.
//   Sub-module scan_tick_gen (parameter SCAN_DIV): prescaler, outputs 1-clk tick.
//   Top holds synchronizer, row index, FSM, debounce/repeat counters.
// TESTING (bench params: SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=6, REPEAT_RATE=2)
//   Reset: reset=0 -> row_out=1110, key_code=0, key_valid=0, key_held=0 immediately.
//   Idle scan: col_in=1111 -> row_out 1110,1101,1011,0111,1110, changing every 4 clk.
//   Press row2/col1 held -> key_code=9, one 1-clk key_valid, key_held=1 until
//     3 high ticks after release, then scanning resumes at row 3 (0111).
//   Bounce: col1 low on one tick only -> no key_valid, key_held stays 0, scan continues.
//   Row0 col1+col3 low together -> key_code=1; reset asserted mid-DEBOUNCE -> no strobe.
//   KEYPAD_REPEAT_EN: key 5 held 16 ticks -> key_valid pulses at accept, +6, +8, +10, ...

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and constants for the 4x4 matrix keypad scanner:
//            FSM state encoding, idle row pattern, row/column widths and a
//            helper for sizing tick counters.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int ROW_N = 4;
    localparam int COL_N = 4;
    localparam int ROW_W = 2;
    localparam int COL_W = 2;

    // Row 0 driven low, all other rows released.
    localparam logic [ROW_N-1:0] ROW_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    // Largest of three tick counts; one counter width then covers debounce,
    // release and auto-repeat counting.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : scan_tick_gen
// Purpose  : Prescaler counting 0..SCAN_DIV-1; emits a one-clock tick on the
//            terminal count, then wraps. Paces all keypad scan decisions.
// Revision : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int SCAN_DIV = 50_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next prescaler value: wrap to zero after the terminal count.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad scanner. Drives one row low at a time, samples
//            synchronized active-low columns, debounces press and release and
//            emits a hex key code with a one-clock valid strobe.
//            Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [COL_N-1:0] col_in,
    output logic [ROW_N-1:0] row_out,
    output logic [3:0]       key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS);

    logic             tick;
    logic [COL_N-1:0] sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_N-1:0] row_out_q, row_out_d;
    logic [COL_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             pick_valid;
    logic [COL_W-1:0] pick_col;
    logic             accept;
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE);
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;
`endif

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= col_in;
            sync2_q <= sync1_q;
        end
    end

    // Lowest-index low column wins when several are pressed.
    always_comb begin
        pick_valid = ~&sync2_q;
        pick_col   = '0;
        for (int i = COL_N - 1; i >= 0; i--) begin
            if (!sync2_q[i]) pick_col = COL_W'(i);
        end
    end

    // Scan/debounce/hold decisions, evaluated only on scan ticks.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
`endif
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (pick_valid) begin
                        cand_d = pick_col;
                        cnt_d  = CNT_W'(1);
                        if (cnt_d == DB_LAST) accept  = 1'b1;
                        else                  state_d = DEBOUNCE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (pick_valid && (pick_col == cand_q)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == DB_LAST) accept = 1'b1;
                    end else begin
                        state_d = SCAN;
                        row_d   = row_q + ROW_W'(1);
                    end
                end
                PRESSED: begin
                    if (sync2_q[cand_q]) begin
                        cnt_d = cnt_q + CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b0;
`endif
                        if (cnt_d == DB_LAST) begin
                            held_d  = 1'b0;
                            state_d = SCAN;
                            row_d   = row_q + ROW_W'(1);
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                        // First repeat after REPEAT_DELAY held ticks, then every REPEAT_RATE.
                        rep_cnt_d = rep_cnt_q + CNT_W'(1);
                        if (rep_cnt_d == (rep_armed_q ? RATE_LAST : DELAY_LAST)) begin
                            valid_d     = 1'b1;
                            rep_cnt_d   = '0;
                            rep_armed_d = 1'b1;
                        end
`endif
                    end
                end
                default: state_d = SCAN;
            endcase

            if (accept) begin
                code_d  = {row_q, cand_d};
                valid_d = 1'b1;
                held_d  = 1'b1;
                state_d = PRESSED;
                cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt_d   = '0;
                rep_armed_d = 1'b0;
`endif
            end
        end
        row_out_d = ~(4'b0001 << row_d);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            row_q     <= '0;
            row_out_q <= ROW_IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            row_out_q <= row_out_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
`endif
        end
    end

    assign row_out   = row_out_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner. A physical keypad model
//            turns a pressed-key mask into column levels; a behavioural model
//            of the scanning rules predicts every output each clock.
//            Auto-repeat scenario active when KEYPAD_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int RD       = 6;
    localparam int RR       = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys  = '0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    wire  [9:0]  dut_vec = {row_out, key_code, key_valid, key_held};

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int         m_div, m_mode, m_row, m_cc, m_n;
`ifdef KEYPAD_REPEAT_EN
    int         m_rep;
`endif
    logic [3:0] m_s1, m_s2, m_code;
    bit         m_valid, m_held;
    logic [9:0] m_vec;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (row_out[r] === 1'b0)) col_in[c] = 1'b0;
    end

    function automatic logic [9:0] pack_exp();
        logic [3:0] r;
        r = ~(4'b0001 << m_row);
        return {r, m_code, m_valid, m_held};
    endfunction

    task automatic m_reset();
        m_div = 0; m_mode = 0; m_row = 0; m_cc = 0; m_n = 0;
`ifdef KEYPAD_REPEAT_EN
        m_rep = 0;
`endif
        m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0; m_valid = 0; m_held = 0;
        m_vec = pack_exp();
    endtask

    // One clock of the scanning rules, given the column level seen at this edge.
    task automatic model_step(input logic [3:0] c);
        logic [3:0] s;
        bit         tk, acc;
        int         low;
        s = m_s2; m_s2 = m_s1; m_s1 = c;
        m_valid = 0; acc = 0;
        tk = (m_div == SCAN_DIV - 1);
        m_div = (m_div + 1) % SCAN_DIV;
        if (tk) begin
            low = -1;
            for (int i = 3; i >= 0; i--) if (s[i] == 1'b0) low = i;
            if (m_mode == 0) begin
                if (low < 0) m_row = (m_row + 1) % 4;
                else begin
                    m_cc = low; m_n = 1;
                    if (m_n == DB) acc = 1; else m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (low == m_cc) begin
                    m_n++;
                    if (m_n == DB) acc = 1;
                end else begin
                    m_mode = 0; m_row = (m_row + 1) % 4;
                end
            end else begin
                if (s[m_cc]) begin
                    m_n++;
`ifdef KEYPAD_REPEAT_EN
                    m_rep = 0;
`endif
                    if (m_n == DB) begin
                        m_held = 0; m_mode = 0; m_row = (m_row + 1) % 4;
                    end
                end else begin
                    m_n = 0;
`ifdef KEYPAD_REPEAT_EN
                    m_rep++;
                    if (m_rep >= RD && ((m_rep - RD) % RR) == 0) m_valid = 1;
`endif
                end
            end
            if (acc) begin
                m_code = 4'(m_row * 4 + m_cc);
                m_valid = 1; m_held = 1; m_mode = 2; m_n = 0;
`ifdef KEYPAD_REPEAT_EN
                m_rep = 0;
`endif
            end
        end
        m_vec = pack_exp();
    endtask

    // Advance one clock from a negedge to the next, stepping the model.
    task automatic cycle();
        logic [3:0] c;
        #1 c = col_in;
        @(posedge clk);
        model_step(c);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL reset_row got=%b exp=1110", row_out); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got=%h exp=0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got=%b exp=0", key_held); end
        m_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [3:0] seq [5];
        seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        keys = '0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (row_out !== seq[k]) begin errors++; $display("FAIL idle_row step=%0d got=%b exp=%b", k, row_out, seq[k]); end
            if (k < 4) begin
                for (int j = 0; j < 4; j++) begin
                    cycle();
                    checks++;
                    if (dut_vec !== m_vec) begin errors++; $display("FAIL idle_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
                end
            end
        end
    endtask

    task automatic test_press_key9();
        int pulses = 0;
        int n = 0;
        keys = 16'h1 << 9;
        while (!m_held && n < 200) begin
            cycle(); n++;
            if (key_valid === 1'b1) pulses++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL press_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
        for (int j = 0; j < 20; j++) begin
            cycle();
            if (key_valid === 1'b1) pulses++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL press_hold_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL press_pulses got=%0d exp=1", pulses); end
        checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL press_code got=%h exp=9", key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held got=%b exp=1", key_held); end
        keys = '0;
        n = 0;
        while (key_held === 1'b1 && n < 100) begin
            cycle(); n++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL release_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
        checks++; if (row_out !== 4'b0111) begin errors++; $display("FAIL release_row got=%b exp=0111", row_out); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held got=%b exp=0", key_held); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int n = 0;
        keys = 16'h1 << 1;
        while (m_mode != 1 && n < 100) begin
            cycle(); n++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL bounce_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
        keys = '0;
        for (int j = 0; j < 20; j++) begin
            cycle();
            if (key_valid === 1'b1) pulses++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL bounce_after_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held got=%b exp=0", key_held); end
    endtask

    task automatic test_multi_col();
        int n = 0;
        keys = (16'h1 << 1) | (16'h1 << 3);
        while (key_valid !== 1'b1 && n < 200) begin
            cycle(); n++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL multi_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
        checks++; if (key_code !== 4'h1) begin errors++; $display("FAIL multi_code got=%h exp=1", key_code); end
        keys = '0;
        n = 0;
        while (key_held === 1'b1 && n < 100) begin
            cycle(); n++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL multi_rel_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
    endtask

    task automatic test_reset_mid_debounce();
        int pulses = 0;
        int n = 0;
        keys = 16'h1 << 6;
        while (m_mode != 1 && n < 100) begin
            cycle(); n++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL rstdb_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
        cycle();
        #2 reset = 1'b0;
        keys = '0;
        #1;
        checks++;
        if (dut_vec !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL rstdb_async got=%b exp=1110000000", dut_vec); end
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 40; j++) begin
            cycle();
            if (key_valid === 1'b1) pulses++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL rstdb_after_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rstdb_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_random();
        int sel, hold;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      keys = '0;
            else if (sel == 3) keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            else               keys = 16'h1 << $urandom_range(0, 15);
            hold = $urandom_range(1, 70);
            for (int j = 0; j < hold; j++) begin
                cycle();
                checks++;
                if (dut_vec !== m_vec) begin errors++; $display("FAIL random_cmp it=%0d t=%0t got=%b exp=%b", it, $time, dut_vec, m_vec); end
            end
        end
        keys = '0;
        for (int j = 0; j < 60; j++) begin
            cycle();
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL random_tail_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        int pulses = 0;
        int n = 0;
        keys = 16'h1 << 5;
        while (key_valid !== 1'b1 && n < 200) begin
            cycle(); n++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL repeat_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
        // 16 held ticks after accept: repeats at +6,+8,+10,+12,+14,+16.
        for (int j = 0; j < 16 * SCAN_DIV; j++) begin
            cycle();
            if (key_valid === 1'b1) pulses++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL repeat_hold_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
        checks++; if (pulses != 6) begin errors++; $display("FAIL repeat_pulses got=%0d exp=6", pulses); end
        checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL repeat_code got=%h exp=5", key_code); end
        keys = '0;
        n = 0;
        while (key_held === 1'b1 && n < 100) begin
            cycle(); n++;
            checks++;
            if (dut_vec !== m_vec) begin errors++; $display("FAIL repeat_rel_cmp t=%0t got=%b exp=%b", $time, dut_vec, m_vec); end
        end
    endtask
`endif

    initial begin
        m_reset();
        test_reset();
        test_idle_scan();
        test_press_key9();
        test_bounce();
        test_multi_col();
        test_reset_mid_debounce();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
